// File: rtl/dma_fifo_sched_pkg.sv
// Shared types for the DMA fifo scheduler:
// FSM state encodings and fifo direction constants.
package dma_fifo_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        XFER_WR = 3'd2,
        XFER_RD = 3'd3,
        CHECK   = 3'd4,
        RETRY   = 3'd5
    } state_t;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

endpackage

// File: rtl/dma_fifo_sched_if.sv
// Bundle of config, producer, consumer and fifo
// signals around the DMA fifo scheduler.
interface dma_fifo_sched_if #(
    parameter int DATA  = 16,
    parameter int LEN_W = 16
);
    logic             cfg_start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             done;
    logic             abort;
    logic             wr_req;
    logic [DATA-1:0]  wr_data;
    logic             wr_gnt;
    logic             rd_req;
    logic             rd_valid;
    logic [DATA-1:0]  rd_data;
    logic             rd_nack;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA-1:0]  fifo_out;
    logic             fifo_enable;
    logic             fifo_wr_rd;
    logic [DATA-1:0]  fifo_in;
    logic             fifo_old_add_flag;

    // scheduler side
    modport slave (
        input  cfg_start, cfg_len,
        input  wr_req, wr_data,
        input  rd_req, rd_nack,
        input  fifo_full, fifo_empty, fifo_out,
        output busy, done, abort,
        output wr_gnt, rd_valid, rd_data,
        output fifo_enable, fifo_wr_rd,
        output fifo_in, fifo_old_add_flag
    );

    // environment side
    modport master (
        output cfg_start, cfg_len,
        output wr_req, wr_data,
        output rd_req, rd_nack,
        output fifo_full, fifo_empty, fifo_out,
        input  busy, done, abort,
        input  wr_gnt, rd_valid, rd_data,
        input  fifo_enable, fifo_wr_rd,
        input  fifo_in, fifo_old_add_flag
    );

endinterface

// File: rtl/dma_fifo_sched_arb.sv
// Two-requester round-robin arbiter: the last
// winner loses a tie; write wins after reset.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_wr,
    input  logic req_rd,
    input  logic take,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic last_wr;

    assign gnt_wr = req_wr & (~req_rd | ~last_wr);
    assign gnt_rd = req_rd & ~gnt_wr;

    // remember who won once the grant is actually used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_wr <= 1'b0;
        end else if (take && (gnt_wr || gnt_rd)) begin
            last_wr <= gnt_wr;
        end
    end

endmodule

// File: rtl/dma_fifo_sched.sv
// Sequencer sharing one fifo port between a producer
// and a consumer, with nack-driven re-reads.
module dma_fifo_sched
    import dma_fifo_sched_pkg::*;
#(
    parameter int DATA      = 16,
    parameter int LEN_W     = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    dma_fifo_sched_if.slave  bus
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] wr_left;
    logic [LEN_W-1:0] rd_left;
    logic [RW-1:0]    retry_q;
    logic             done_q;
    logic             abort_q;

    logic             done_d;
    logic             abort_d;
    logic             load;
    logic             wr_dec;
    logic             rd_dec;
    logic             retry_inc;
    logic             retry_clr;
    logic             take;

    logic             wr_elig;
    logic             rd_elig;
    logic             arb_wr;
    logic             gnt_wr;
    logic             gnt_rd;

    logic             en;
    logic             wr_rd;
    logic             old;
    logic             gnt;
    logic             valid;

    logic [DATA-1:0]  pass_in;
    logic [DATA-1:0]  pass_out;

    assign pass_in  = bus.wr_data;
    assign pass_out = bus.fifo_out;
    assign bus.fifo_in = pass_in;
    assign bus.rd_data = pass_out;

    assign wr_elig = bus.wr_req & ~bus.fifo_full
                   & (wr_left != '0);
    assign rd_elig = bus.rd_req & ~bus.fifo_empty
                   & (rd_left != '0);

    // a write in progress only chains if a word remains after it
    assign arb_wr = (state_q == XFER_WR)
                  ? (wr_elig & (wr_left != LEN_W'(1)))
                  : wr_elig;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_wr (arb_wr),
        .req_rd (rd_elig),
        .take   (take),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, fifo strobes and counter controls
    always_comb begin
        state_d   = state_q;
        en        = 1'b0;
        wr_rd     = DIR_RD;
        old       = 1'b0;
        gnt       = 1'b0;
        valid     = 1'b0;
        take      = 1'b0;
        load      = 1'b0;
        wr_dec    = 1'b0;
        rd_dec    = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    if (bus.cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                wr_rd = gnt_wr ? DIR_WR : DIR_RD;
                if (gnt_wr) begin
                    take    = 1'b1;
                    state_d = XFER_WR;
                end else if (gnt_rd) begin
                    take    = 1'b1;
                    state_d = XFER_RD;
                end
            end
            XFER_WR: begin
                wr_rd  = DIR_WR;
                en     = wr_elig;
                gnt    = wr_elig;
                wr_dec = wr_elig;
                if (gnt_wr) begin
                    take    = 1'b1;
                    state_d = XFER_WR;
                end else begin
                    state_d = SETUP;
                end
            end
            XFER_RD: begin
                en      = 1'b1;
                valid   = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                old = 1'b1;
                if (bus.rd_nack) begin
                    retry_inc = 1'b1;
                    if (retry_q + RW'(1) == RW'(MAX_RETRY)) begin
                        abort_d   = 1'b1;
                        retry_clr = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = RETRY;
                    end
                end else begin
                    rd_dec    = 1'b1;
                    retry_clr = 1'b1;
                    if (rd_left <= LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            RETRY: begin
                en      = 1'b1;
                old     = 1'b1;
                valid   = 1'b1;
                state_d = CHECK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // words left to write / read; never wrap below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_left <= '0;
            rd_left <= '0;
        end else if (load) begin
            wr_left <= bus.cfg_len;
            rd_left <= bus.cfg_len;
        end else begin
            if (wr_dec && wr_left != '0) begin
                wr_left <= wr_left - LEN_W'(1);
            end
            if (rd_dec && rd_left != '0) begin
                rd_left <= rd_left - LEN_W'(1);
            end
        end
    end

    // consecutive nacks on the current word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= '0;
        end else if (load || retry_clr) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + RW'(1);
        end
    end

    // completion pulses, registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = done_q;
    assign bus.abort             = abort_q;
    assign bus.wr_gnt            = gnt;
    assign bus.rd_valid          = valid;
    assign bus.fifo_enable       = en;
    assign bus.fifo_wr_rd        = wr_rd;
    assign bus.fifo_old_add_flag = old;

endmodule

// File: tb/tb_dma_fifo_sched.sv
// Directed bench for dma_fifo_sched with a small
// fifo model, producer and nacking consumer.
module tb_dma_fifo_sched;

    localparam int DATA  = 16;
    localparam int LEN_W = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dma_fifo_sched_if #(.DATA(DATA), .LEN_W(LEN_W)) bus ();

    dma_fifo_sched #(
        .DATA(DATA), .LEN_W(LEN_W), .MAX_RETRY(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // fifo model with old-address re-read
    logic [DATA-1:0] mem [DEPTH];
    logic [1:0]      wp, rp, oa;
    logic [2:0]      cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0; rp <= '0; oa <= '0; cnt <= '0;
        end else if (bus.fifo_enable) begin
            if (bus.fifo_wr_rd) begin
                mem[wp] <= bus.fifo_in;
                wp  <= wp + 2'd1;
                cnt <= cnt + 3'd1;
            end else if (!bus.fifo_old_add_flag) begin
                oa  <= rp;
                rp  <= rp + 2'd1;
                cnt <= cnt - 3'd1;
            end
        end
    end

    assign bus.fifo_full  = (cnt == 3'(DEPTH));
    assign bus.fifo_empty = (cnt == 3'd0);
    assign bus.fifo_out   = bus.fifo_old_add_flag ? mem[oa] : mem[rp];

    // producer: word index advances after each grant
    int          p_idx   = 0;
    int          p_start = 0;
    int          p_end   = 0;
    logic [15:0] p_base  = 16'h0;
    logic        p_seen  = 1'b0;

    always @(negedge clk) begin
        if (p_seen) p_idx++;
        bus.wr_req  = (p_idx < p_end);
        bus.wr_data = p_base + 16'(p_idx - p_start);
        #1;
        p_seen = bus.wr_gnt;
    end

    // monitor, rule checks and nacking consumer
    int          gnt_cnt = 0, en_cnt = 0, done_cnt = 0;
    int          abort_cnt = 0, rty_cnt = 0, nval = 0, viol = 0;
    int          nack_mode = 0, nval_b = 0;
    logic        pend = 1'b0, prev_dir = 1'b0;
    logic [15:0] rdq [$];

    always @(negedge clk) begin
        #2;
        bus.rd_nack = pend;
        pend = 1'b0;
        if (bus.fifo_enable && bus.fifo_wr_rd && bus.fifo_full) viol++;
        if (bus.fifo_enable && !bus.fifo_wr_rd
            && !bus.fifo_old_add_flag && bus.fifo_empty) viol++;
        if (bus.fifo_enable && bus.fifo_wr_rd != prev_dir) viol++;
        if ((bus.done || bus.abort) && bus.busy) viol++;
        prev_dir = bus.fifo_wr_rd;
        if (bus.wr_gnt) gnt_cnt++;
        if (bus.fifo_enable) en_cnt++;
        if (bus.done) done_cnt++;
        if (bus.abort) abort_cnt++;
        if (bus.rd_valid) begin
            nval++;
            rdq.push_back(bus.rd_data);
            if (bus.fifo_enable && bus.fifo_old_add_flag) rty_cnt++;
            pend = (nack_mode == 2)
                || (nack_mode == 1 && nval - nval_b == 2);
        end
    end

    int b_gnt, b_en, b_done, b_abort, b_rty, b_viol, b_q;

    // snapshot monitor counts and arm the producer for n words
    task automatic clr(input logic [15:0] base, input int n);
        @(negedge clk);
        #3;
        b_gnt = gnt_cnt; b_en = en_cnt; b_done = done_cnt;
        b_abort = abort_cnt; b_rty = rty_cnt; b_viol = viol;
        b_q = rdq.size(); nval_b = nval;
        p_base = base; p_start = p_idx; p_end = p_idx + n;
    endtask

    task automatic start(input logic [15:0] len);
        @(negedge clk);
        bus.cfg_start = 1'b1;
        bus.cfg_len   = len;
        @(negedge clk);
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int max);
        int k = 0;
        while ((done_cnt - b_done) + (abort_cnt - b_abort) == 0
               && k < max) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk(tag, 32'((done_cnt - b_done) + (abort_cnt - b_abort) != 0), 1);
    endtask

    function automatic logic [7:0] outs();
        return {bus.busy, bus.done, bus.abort, bus.wr_gnt,
                bus.rd_valid, bus.fifo_enable, bus.fifo_wr_rd,
                bus.fifo_old_add_flag};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_len   = '0;
        bus.rd_req    = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("rst_out", 32'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_out", 32'(outs()), 0);

        // write streak of 4, then drain
        clr(16'h1000, 4);
        start(16'd4);
        #1 chk("a_setup", {bus.busy, bus.fifo_enable,
                           bus.fifo_wr_rd, bus.wr_gnt}, 32'b1010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("a_wr", {bus.fifo_enable, bus.fifo_wr_rd,
                            bus.wr_gnt}, 32'b111);
        end
        @(negedge clk);
        #1 chk("a_stop", {bus.fifo_enable, bus.wr_gnt}, 0);
        repeat (3) @(negedge clk);
        #3 chk("a_en", 32'(en_cnt - b_en), 4);
        chk("a_busy", 32'(bus.busy), 1);
        bus.rd_req = 1'b1;
        wait_end("a_end", 60);
        chk("a_done", 32'(done_cnt - b_done), 1);
        chk("a_nrd", 32'(rdq.size() - b_q), 4);
        for (int i = 0; i < 4; i++)
            chk("a_data", 32'(rdq[b_q + i]), 32'(16'h1000 + i));
        chk("a_viol", 32'(viol - b_viol), 0);
        chk("a_idle", 32'(bus.busy), 0);

        // 6 words through a 4-deep fifo: stall when full
        bus.rd_req = 1'b0;
        clr(16'h2000, 6);
        start(16'd6);
        repeat (12) @(negedge clk);
        #3 chk("b_gnt", 32'(gnt_cnt - b_gnt), 4);
        chk("b_en", 32'(en_cnt - b_en), 4);
        bus.rd_req = 1'b1;
        wait_end("b_end", 100);
        chk("b_done", 32'(done_cnt - b_done), 1);
        chk("b_nrd", 32'(rdq.size() - b_q), 6);
        for (int i = 0; i < 6; i++)
            chk("b_data", 32'(rdq[b_q + i]), 32'(16'h2000 + i));
        chk("b_viol", 32'(viol - b_viol), 0);

        // both sides active, words A,B,C
        clr(16'h000A, 3);
        start(16'd3);
        wait_end("c_end", 60);
        chk("c_done", 32'(done_cnt - b_done), 1);
        chk("c_abort", 32'(abort_cnt - b_abort), 0);
        chk("c_nrd", 32'(rdq.size() - b_q), 3);
        for (int i = 0; i < 3; i++)
            chk("c_data", 32'(rdq[b_q + i]), 32'(16'h000A + i));
        chk("c_rty", 32'(rty_cnt - b_rty), 0);
        chk("c_viol", 32'(viol - b_viol), 0);

        // nack B once: A,B,B,C presented
        nack_mode = 1;
        clr(16'h000A, 3);
        start(16'd3);
        wait_end("d_end", 80);
        chk("d_done", 32'(done_cnt - b_done), 1);
        chk("d_nrd", 32'(rdq.size() - b_q), 4);
        chk("d_w0", 32'(rdq[b_q + 0]), 32'h0A);
        chk("d_w1", 32'(rdq[b_q + 1]), 32'h0B);
        chk("d_w2", 32'(rdq[b_q + 2]), 32'h0B);
        chk("d_w3", 32'(rdq[b_q + 3]), 32'h0C);
        chk("d_rty", 32'(rty_cnt - b_rty), 1);
        chk("d_viol", 32'(viol - b_viol), 0);

        // nack forever: 3 presentations then abort
        nack_mode = 2;
        clr(16'h0050, 2);
        start(16'd2);
        wait_end("e_end", 80);
        chk("e_abort", 32'(abort_cnt - b_abort), 1);
        chk("e_done", 32'(done_cnt - b_done), 0);
        chk("e_nrd", 32'(rdq.size() - b_q), 3);
        for (int i = 0; i < 3; i++)
            chk("e_data", 32'(rdq[b_q + i]), 32'h50);
        chk("e_rty", 32'(rty_cnt - b_rty), 2);
        chk("e_busy", 32'(bus.busy), 0);
        @(negedge clk);
        #1 chk("e_pulse", 32'(bus.abort), 0);
        nack_mode = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // zero length: done next cycle, no access
        bus.rd_req = 1'b0;
        clr(16'h0000, 0);
        start(16'd0);
        #1 chk("f_done", {bus.done, bus.busy, bus.fifo_enable}, 32'b100);
        @(negedge clk);
        #1 chk("f_pulse", 32'(bus.done), 0);
        #2 chk("f_en", 32'(en_cnt - b_en), 0);

        // start while busy is ignored
        clr(16'h0070, 2);
        start(16'd2);
        repeat (6) @(negedge clk);
        start(16'd9);
        repeat (2) @(negedge clk);
        #3 chk("g_busy", 32'(bus.busy), 1);
        chk("g_early", 32'(done_cnt - b_done), 0);
        bus.rd_req = 1'b1;
        wait_end("g_end", 60);
        chk("g_nrd", 32'(rdq.size() - b_q), 2);
        chk("g_w1", 32'(rdq[b_q + 1]), 32'h71);
        repeat (4) @(negedge clk);
        #3 chk("g_done", 32'(done_cnt - b_done), 1);
        chk("g_idle", 32'(bus.busy), 0);

        // reset during a write, then a fresh transfer
        bus.rd_req = 1'b0;
        clr(16'h0090, 4);
        start(16'd4);
        @(negedge clk);
        #1 chk("h_pre", {bus.fifo_enable, bus.wr_gnt}, 32'b11);
        rst = 1'b1;
        #1 chk("h_rst", 32'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        p_end = 0;
        repeat (3) @(negedge clk);
        #3 chk("h_nodone", 32'((done_cnt - b_done) + (abort_cnt - b_abort)), 0);
        chk("h_idle", 32'(bus.busy), 0);
        bus.rd_req = 1'b1;
        clr(16'h00C0, 1);
        start(16'd1);
        wait_end("h_end", 40);
        chk("h_done", 32'(done_cnt - b_done), 1);
        chk("h_nrd", 32'(rdq.size() - b_q), 1);
        chk("h_data", 32'(rdq[b_q]), 32'hC0);
        chk("h_viol", 32'(viol - b_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
